// File: rtl/gic_slave_wide.sv
// GIC link slave: receives request frames over a LINK_W-bit link, runs them as
// classic Wishbone cycles and returns a coded status (plus read data) to the master.
module gic_slave_wide #(
  parameter int                LINK_W  = 4,
  parameter logic [LINK_W-1:0] IDLE    = {LINK_W{1'b1}},
  parameter int                TIMEOUT = 256
) (
  input  logic              wbm_clk_i,
  input  logic              wbm_rst_i,
  output logic [31:0]       wbm_adr_o,
  output logic [31:0]       wbm_dat_o,
  output logic [3:0]        wbm_sel_o,
  output logic              wbm_we_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic [2:0]        wbm_cti_o,
  output logic [1:0]        wbm_bte_o,
  input  logic [31:0]       wbm_dat_i,
  input  logic              wbm_ack_i,
  input  logic              wbm_err_i,
  input  logic              wbm_rty_i,
  input  logic [LINK_W-1:0] gic_dat_i,
  output logic [LINK_W-1:0] gic_dat_o,
  output logic              cksum_err_o
);

  localparam int                BEATS     = 32 / LINK_W;
  localparam logic [LINK_W-1:0] MI        = {LINK_W/4{4'b1010}};
  localparam logic [LINK_W-1:0] SI        = {LINK_W/4{4'b0101}};
  localparam logic [LINK_W-1:0] K         = {LINK_W/4{4'b1100}};
  localparam logic [3:0]        LAST_BEAT = 4'(BEATS - 1);
  localparam logic [15:0]       TMO_LAST  = 16'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    M_INIT, M_CMD, M_SEL, M_ADR, M_DAT, M_CKSUM,
    WB_CYC, S_INIT, S_RESP, S_DAT, S_CKSUM
  } state_t;

  state_t              state_reg, state_next;
  logic                we_reg;
  logic [3:0]          sel_reg;
  logic [31:0]         adr_reg, dat_reg, rdat_reg;
  logic [LINK_W-1:0]   cksum_reg, rsum_reg;
  logic [3:0]          beat_reg;
  logic [15:0]         timer_reg;
  logic [2:0]          status_reg;
  logic                cksum_err_reg;
  logic                beat_last;
  logic                wb_term;
  logic [LINK_W-1:0]   beat_k;

  assign beat_last = (beat_reg == LAST_BEAT);
  assign wb_term   = wbm_ack_i | wbm_err_i | wbm_rty_i;
  // The last beat of every word is folded with K so all-zero/all-one words cannot pass.
  assign beat_k    = beat_last ? K : {LINK_W{1'b0}};

  always_comb begin
    state_next = state_reg;
    gic_dat_o  = IDLE;
    case (state_reg)
      M_INIT:  if (gic_dat_i == MI) state_next = M_CMD;
      M_CMD:   state_next = M_SEL;
      M_SEL:   state_next = M_ADR;
      M_ADR:   if (beat_last) state_next = we_reg ? M_DAT : M_CKSUM;
      M_DAT:   if (beat_last) state_next = M_CKSUM;
      M_CKSUM: state_next = (gic_dat_i == cksum_reg) ? WB_CYC : S_INIT;
      WB_CYC:  if (wb_term || timer_reg == TMO_LAST) state_next = S_INIT;
      S_INIT: begin
        gic_dat_o  = SI;
        state_next = S_RESP;
      end
      S_RESP: begin
        gic_dat_o  = {{(LINK_W-3){1'b0}}, status_reg};
        state_next = (!we_reg && status_reg == 3'd0) ? S_DAT : M_INIT;
      end
      S_DAT: begin
        gic_dat_o = rdat_reg[31 -: LINK_W];
        if (beat_last) state_next = S_CKSUM;
      end
      S_CKSUM: begin
        gic_dat_o  = rsum_reg;
        state_next = M_INIT;
      end
      default: state_next = M_INIT;
    endcase
  end

  always_ff @(posedge wbm_clk_i) begin
    if (wbm_rst_i) begin
      state_reg     <= M_INIT;
      we_reg        <= 1'b0;
      sel_reg       <= 4'd0;
      adr_reg       <= 32'd0;
      dat_reg       <= 32'd0;
      rdat_reg      <= 32'd0;
      cksum_reg     <= {LINK_W{1'b0}};
      rsum_reg      <= {LINK_W{1'b0}};
      beat_reg      <= 4'd0;
      timer_reg     <= 16'd0;
      status_reg    <= 3'd0;
      cksum_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cksum_err_reg <= 1'b0;
      case (state_reg)
        M_CMD: we_reg <= gic_dat_i[LINK_W-1];
        M_SEL: begin
          sel_reg   <= gic_dat_i[3:0];
          cksum_reg <= gic_dat_i;
          beat_reg  <= 4'd0;
        end
        M_ADR: begin
          adr_reg   <= {adr_reg[31-LINK_W:0], gic_dat_i};
          cksum_reg <= cksum_reg ^ gic_dat_i ^ beat_k;
          beat_reg  <= beat_last ? 4'd0 : beat_reg + 4'd1;
        end
        M_DAT: begin
          dat_reg   <= {dat_reg[31-LINK_W:0], gic_dat_i};
          cksum_reg <= cksum_reg ^ gic_dat_i ^ beat_k;
          beat_reg  <= beat_last ? 4'd0 : beat_reg + 4'd1;
        end
        M_CKSUM: begin
          timer_reg <= 16'd0;
          if (gic_dat_i != cksum_reg) begin
            cksum_err_reg <= 1'b1;
            status_reg    <= 3'd3;
          end
        end
        WB_CYC: begin
          timer_reg <= timer_reg + 16'd1;
          if (wbm_ack_i) begin
            status_reg <= 3'd0;
            rdat_reg   <= wbm_dat_i;
          end else if (wbm_err_i) begin
            status_reg <= 3'd1;
          end else if (wbm_rty_i) begin
            status_reg <= 3'd2;
          end else if (timer_reg == TMO_LAST) begin
            status_reg <= 3'd4;
          end
        end
        S_RESP: begin
          rsum_reg <= {LINK_W{1'b0}};
          beat_reg <= 4'd0;
        end
        S_DAT: begin
          rdat_reg <= {rdat_reg[31-LINK_W:0], {LINK_W{1'b0}}};
          rsum_reg <= rsum_reg ^ rdat_reg[31 -: LINK_W] ^ beat_k;
          beat_reg <= beat_last ? 4'd0 : beat_reg + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign wbm_cyc_o   = (state_reg == WB_CYC);
  assign wbm_stb_o   = wbm_cyc_o;
  assign wbm_we_o    = we_reg & wbm_cyc_o;
  assign wbm_adr_o   = adr_reg;
  assign wbm_dat_o   = dat_reg;
  assign wbm_sel_o   = sel_reg;
  assign wbm_cti_o   = 3'b000;
  assign wbm_bte_o   = 2'b00;
  assign cksum_err_o = cksum_err_reg;

endmodule

// File: tb/tb_gic_slave_wide.sv
// Bench for gic_slave_wide: 4-bit and 8-bit link instances share clock, reset and
// Wishbone terminations; a vector table plus reset sequences, responses via a scoreboard queue.
module tb_gic_slave_wide;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] rdat_i = 32'd0;
  logic        ack = 1'b0, err = 1'b0, rty = 1'b0;
  logic [3:0]  gi4 = 4'hF;
  logic [7:0]  gi8 = 8'hFF;

  logic [31:0] adr4, dat4, adr8, dat8;
  logic [3:0]  sel4, sel8, o4;
  logic [7:0]  o8;
  logic [2:0]  cti4, cti8;
  logic [1:0]  bte4, bte8;
  logic        we4, cyc4, stb4, ce4, we8, cyc8, stb8, ce8;

  always #5 clk = ~clk;

  gic_slave_wide #(.LINK_W(4), .TIMEOUT(16)) u4 (
    .wbm_clk_i(clk), .wbm_rst_i(rst), .wbm_adr_o(adr4), .wbm_dat_o(dat4),
    .wbm_sel_o(sel4), .wbm_we_o(we4), .wbm_cyc_o(cyc4), .wbm_stb_o(stb4),
    .wbm_cti_o(cti4), .wbm_bte_o(bte4), .wbm_dat_i(rdat_i), .wbm_ack_i(ack),
    .wbm_err_i(err), .wbm_rty_i(rty), .gic_dat_i(gi4), .gic_dat_o(o4),
    .cksum_err_o(ce4));

  gic_slave_wide #(.LINK_W(8), .TIMEOUT(16)) u8 (
    .wbm_clk_i(clk), .wbm_rst_i(rst), .wbm_adr_o(adr8), .wbm_dat_o(dat8),
    .wbm_sel_o(sel8), .wbm_we_o(we8), .wbm_cyc_o(cyc8), .wbm_stb_o(stb8),
    .wbm_cti_o(cti8), .wbm_bte_o(bte8), .wbm_dat_i(rdat_i), .wbm_ack_i(ack),
    .wbm_err_i(err), .wbm_rty_i(rty), .gic_dat_i(gi8), .gic_dat_o(o8),
    .cksum_err_o(ce8));

  // View of whichever instance is currently exercised.
  int          cur_w = 8;
  logic        cyc_m, stb_m, we_m, ce_m;
  logic [31:0] adr_m, dat_m;
  logic [3:0]  sel_m;
  logic [7:0]  out_m, idle_m;

  always_comb begin
    if (cur_w == 8) begin
      cyc_m = cyc8; stb_m = stb8; we_m = we8; ce_m = ce8;
      adr_m = adr8; dat_m = dat8; sel_m = sel8; out_m = o8; idle_m = 8'hFF;
    end else begin
      cyc_m = cyc4; stb_m = stb4; we_m = we4; ce_m = ce4;
      adr_m = adr4; dat_m = dat4; sel_m = sel4; out_m = {4'h0, o4}; idle_m = 8'h0F;
    end
  end

  typedef struct {
    int          w;
    bit          we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] rdat;
    logic [2:0]  term;    // {rty, err, ack}; 0 = never terminate
    int          delay;   // cyc cycles before the termination is raised
    bit          bad;     // corrupt the checksum
    logic [2:0]  status;
  } vec_t;

  vec_t       vecs[8];
  logic [7:0] exp_q[$];
  int         n_vec = 0;
  int         n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] beat_of(input logic [31:0] word, input int w, input int i);
    logic [31:0] t;
    t = (word >> (32 - w * (i + 1))) & ((32'd1 << w) - 32'd1);
    return t[7:0];
  endfunction

  task automatic drive(input logic [7:0] s);
    @(negedge clk);
    if (cur_w == 8) gi8 = s;
    else gi4 = s[3:0];
  endtask

  task automatic link_idle();
    gi8 = 8'hFF;
    gi4 = 4'hF;
  endtask

  // Drives a full request frame; returns at the first negedge after the CKSUM symbol.
  task automatic send_frame(input vec_t v);
    int         beats;
    logic [7:0] k, ck, b;
    beats = 32 / v.w;
    k     = (v.w == 8) ? 8'hCC : 8'h0C;
    drive((v.w == 8) ? 8'hAA : 8'h0A);
    drive(v.we ? ((v.w == 8) ? 8'h80 : 8'h08) : 8'h00);
    drive({4'h0, v.sel});
    ck = {4'h0, v.sel};
    for (int i = 0; i < beats; i++) begin
      b  = beat_of(v.adr, v.w, i);
      ck = ck ^ b ^ ((i == beats - 1) ? k : 8'h00);
      drive(b);
    end
    if (v.we) begin
      for (int i = 0; i < beats; i++) begin
        b  = beat_of(v.dat, v.w, i);
        ck = ck ^ b ^ ((i == beats - 1) ? k : 8'h00);
        drive(b);
      end
    end
    if (v.bad) ck = ck ^ 8'h01;
    drive(ck);
    @(negedge clk);
    link_idle();
  endtask

  task automatic run_vec(input int idx);
    vec_t       v;
    int         beats, cyc_cnt, last_cyc_t, first_t, exp_cyc;
    bit         done;
    logic [7:0] k, rs, b, e;
    v     = vecs[idx];
    cur_w = v.w;
    beats = 32 / v.w;
    k     = (v.w == 8) ? 8'hCC : 8'h0C;
    rdat_i = v.rdat;
    exp_q.push_back((v.w == 8) ? 8'h55 : 8'h05);
    exp_q.push_back({5'd0, v.status});
    if (!v.we && v.status == 3'd0) begin
      rs = 8'h00;
      for (int i = 0; i < beats; i++) begin
        b  = beat_of(v.rdat, v.w, i);
        rs = rs ^ b ^ ((i == beats - 1) ? k : 8'h00);
        exp_q.push_back(b);
      end
      exp_q.push_back(rs);
    end
    exp_cyc = v.bad ? 0 : ((v.term == 3'd0) ? 16 : v.delay + 1);

    send_frame(v);
    chk("cksum_err_pulse", 32'(ce_m), 32'(v.bad));
    cyc_cnt = 0; last_cyc_t = -1; first_t = -1; done = 1'b0;
    for (int t = 0; t < 64 && !done; t++) begin
      if (cyc_m) begin
        cyc_cnt++;
        last_cyc_t = t;
        if (cyc_cnt == 1) begin
          chk("wb_adr", adr_m, v.adr);
          chk("wb_sel", 32'(sel_m), 32'(v.sel));
          chk("wb_we", 32'(we_m), 32'(v.we));
          chk("wb_stb", 32'(stb_m), 32'd1);
          if (v.we) chk("wb_dat", dat_m, v.dat);
        end
        if (v.term != 3'd0 && cyc_cnt == v.delay + 1) {rty, err, ack} = v.term;
        else {rty, err, ack} = 3'b000;
      end else begin
        {rty, err, ack} = 3'b000;
      end
      if (first_t < 0 && out_m != idle_m) first_t = t;
      if (first_t >= 0) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("resp_sym", 32'(out_m), 32'(e));
        end else begin
          chk("resp_end_idle", 32'(out_m), 32'(idle_m));
          done = 1'b1;
        end
      end
      if (!done) @(negedge clk);
    end
    {rty, err, ack} = 3'b000;
    if (!done) begin
      n_vec++;
      n_bad++;
      $display("FAIL response_timeout: vec %0d got %0d symbols left, required 0", idx, exp_q.size());
      exp_q.delete();
    end
    chk("cyc_cycles", 32'(cyc_cnt), 32'(exp_cyc));
    chk("si_latency", 32'(first_t), 32'(last_cyc_t + 1));
    $display("vec %0d: w=%0d we=%0b adr=%08h status=%0d cyc_cycles=%0d", idx, v.w, v.we,
             v.adr, v.status, cyc_cnt);
  endtask

  initial begin
    bit         stayed_idle;
    vec_t       hv;
    //            w  we  sel   adr           dat           rdat          term    dly bad st
    vecs[0] = '{4, 1'b1, 4'hF, 32'h1000_0040, 32'hDEAD_BEEF, 32'h0,         3'b001, 3, 1'b0, 3'd0};
    vecs[1] = '{8, 1'b0, 4'hF, 32'h2000_0000, 32'h0,         32'h1234_5678, 3'b001, 0, 1'b0, 3'd0};
    vecs[2] = '{8, 1'b1, 4'hF, 32'h3000_0010, 32'hCAFE_F00D, 32'h0,         3'b001, 0, 1'b1, 3'd3};
    vecs[3] = '{8, 1'b0, 4'hF, 32'h4000_0000, 32'h0,         32'h0,         3'b000, 0, 1'b0, 3'd4};
    vecs[4] = '{8, 1'b0, 4'hF, 32'h5000_0004, 32'h0,         32'h1111_1111, 3'b110, 0, 1'b0, 3'd1};
    vecs[5] = '{4, 1'b0, 4'h3, 32'h6000_0008, 32'h0,         32'h0,         3'b100, 2, 1'b0, 3'd2};
    vecs[6] = '{4, 1'b0, 4'hC, 32'h7000_0000, 32'h0,         32'hA5C3_0E96, 3'b001, 1, 1'b0, 3'd0};
    vecs[7] = '{8, 1'b1, 4'h5, 32'h8000_0020, 32'h0123_4567, 32'h0,         3'b010, 2, 1'b0, 3'd1};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int w = 4; w <= 8; w += 4) begin
      cur_w = w;
      #1;
      chk("rst_cyc", 32'(cyc_m), 32'd0);
      chk("rst_adr", adr_m, 32'd0);
      chk("rst_sel_we", {27'd0, sel_m, we_m}, 32'd0);
      chk("rst_cksum_err", 32'(ce_m), 32'd0);
      chk("rst_link", 32'(out_m), 32'(idle_m));
    end
    chk("rst_cti_bte", {22'd0, cti4, bte4, cti8, bte8}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(i);

    // Reset in the middle of the address beats.
    hv = vecs[1];
    cur_w = 8;
    drive(8'hAA); drive(8'h00); drive(8'h0F); drive(8'h20); drive(8'h00);
    @(negedge clk);
    link_idle();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_adr_cyc", 32'(cyc_m), 32'd0);
    chk("rst_adr_link", 32'(out_m), 32'(idle_m));
    rst = 1'b0;
    $display("seq: reset during M_ADR");
    run_vec(1);

    // Reset while a Wishbone cycle is waiting for termination.
    hv = vecs[3];
    cur_w = 8;
    send_frame(hv);
    repeat (2) @(negedge clk);
    chk("pre_rst_cyc", 32'(cyc_m), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_wb_cyc", 32'(cyc_m), 32'd0);
    chk("rst_wb_link", 32'(out_m), 32'(idle_m));
    rst = 1'b0;
    stayed_idle = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (out_m != idle_m || cyc_m) stayed_idle = 1'b0;
    end
    chk("no_resp_after_rst", 32'(stayed_idle), 32'd1);
    $display("seq: reset during WB_CYC");
    // Non-MI symbols before the frame must be ignored.
    drive(8'h55);
    drive(8'h00);
    link_idle();
    run_vec(0);
    run_vec(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end

endmodule
